// File: rtl/npc_pc_unit_if.sv
// Fetch-PC bus between the ID/exception logic and the PC unit.
// The slave side is the PC unit itself; master is whoever drives redirects.
interface npc_pc_unit_if #(
  parameter int unsigned AW = 32
);
  logic          stall;
  logic [2:0]    npc_sel;
  logic [2:0]    br_cond;
  logic [25:0]   imm;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] rs_val;
  logic [AW-1:0] rt_val;
  logic          exc_req;
  logic [AW-1:0] exc_pc;
  logic          exc_bd;
  logic          eret;
  logic [AW-1:0] pc;
  logic          boj;
  logic [AW-1:0] link;
  logic [AW-1:0] epc;
  logic          id_bd;
  logic          jr_misalign;

  modport slave (
    input  stall, npc_sel, br_cond, imm, id_pc, rs_val, rt_val,
           exc_req, exc_pc, exc_bd, eret,
    output pc, boj, link, epc, id_bd, jr_misalign
  );

  modport master (
    output stall, npc_sel, br_cond, imm, id_pc, rs_val, rt_val,
           exc_req, exc_pc, exc_bd, eret,
    input  pc, boj, link, epc, id_bd, jr_misalign
  );
endinterface

// File: rtl/npc_pc_unit.sv
// Fetch-PC unit: owns the PC, resolves branches/jumps in ID with one delay slot,
// and handles exception entry, ERET return and the EPC register.
module npc_pc_unit #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000),
  parameter logic [AW-1:0] EXC_PC   = AW'(32'h0000_4180)
) (
  input logic              clk,
  input logic              reset,
  npc_pc_unit_if.slave     bus
);

  localparam logic [2:0] SEL_BR = 3'b001;
  localparam logic [2:0] SEL_J  = 3'b010;
  localparam logic [2:0] SEL_JR = 3'b011;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LEZ = 3'b010;
  localparam logic [2:0] BR_GTZ = 3'b011;
  localparam logic [2:0] BR_LTZ = 3'b100;
  localparam logic [2:0] BR_GEZ = 3'b101;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] epc_q, epc_d;
  logic          bd_q, bd_d;
  logic          mis_q, mis_d;

  logic          cond;
  logic          taken;
  logic          is_ctl;
  logic          rs_neg;
  logic          rs_zero;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] target;

  // Branch condition and redirect target, resolved from ID-stage operands
  always_comb begin
    rs_neg  = bus.rs_val[AW-1];
    rs_zero = (bus.rs_val == '0);
    cond    = 1'b0;
    case (bus.br_cond)
      BR_EQ:   cond = (bus.rs_val == bus.rt_val);
      BR_NE:   cond = (bus.rs_val != bus.rt_val);
      BR_LEZ:  cond = rs_neg | rs_zero;
      BR_GTZ:  cond = ~rs_neg & ~rs_zero;
      BR_LTZ:  cond = rs_neg;
      BR_GEZ:  cond = ~rs_neg;
      default: cond = 1'b0;
    endcase

    is_ctl = (bus.npc_sel == SEL_BR) || (bus.npc_sel == SEL_J) || (bus.npc_sel == SEL_JR);
    taken  = ((bus.npc_sel == SEL_BR) && cond) || (bus.npc_sel == SEL_J) || (bus.npc_sel == SEL_JR);

    br_tgt = bus.id_pc + AW'(4) + {{(AW-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};
    j_tgt  = {bus.id_pc[AW-1:28], bus.imm, 2'b00};

    target = br_tgt;
    case (bus.npc_sel)
      SEL_J:   target = j_tgt;
      SEL_JR:  target = bus.rs_val;
      default: target = br_tgt;
    endcase
  end

  // Next-state selection: exception > eret > stall > redirect > sequential
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    bd_d  = bd_q;
    mis_d = 1'b0;
    if (bus.exc_req) begin
      pc_d  = EXC_PC;
      epc_d = bus.exc_bd ? (bus.exc_pc - AW'(4)) : bus.exc_pc;
      bd_d  = 1'b0;
    end else if (bus.eret) begin
      pc_d = epc_q;
      bd_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d  = taken ? target : (pc_q + AW'(4));
      bd_d  = is_ctl;
      mis_d = (bus.npc_sel == SEL_JR) && (bus.rs_val[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      bd_q  <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      bd_q  <= bd_d;
      mis_q <= mis_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.epc         = epc_q;
  assign bus.id_bd       = bd_q;
  assign bus.jr_misalign = mis_q;
  assign bus.boj         = taken;
  assign bus.link        = bus.id_pc + AW'(8);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Bench for npc_pc_unit: directed scenarios followed by randomized traffic,
// all compared against an architectural next-PC model.
module tb_npc_pc_unit;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  npc_pc_unit_if #(.AW(32)) bus ();

  npc_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural state of the model
  logic [31:0] m_pc, m_epc;
  logic        m_bd, m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_taken();
    int  rs_s;
    logic c;
    rs_s = int'(bus.rs_val);
    case (bus.br_cond)
      3'd0:    c = (bus.rs_val == bus.rt_val);
      3'd1:    c = (bus.rs_val != bus.rt_val);
      3'd2:    c = (rs_s <= 0);
      3'd3:    c = (rs_s > 0);
      3'd4:    c = (rs_s < 0);
      3'd5:    c = (rs_s >= 0);
      default: c = 1'b0;
    endcase
    return (bus.npc_sel == 3'd1 && c) || bus.npc_sel == 3'd2 || bus.npc_sel == 3'd3;
  endfunction

  function automatic logic [31:0] model_target();
    logic [15:0] off16;
    int          off;
    off16 = bus.imm[15:0];
    off   = int'($signed(off16)) * 4;
    case (bus.npc_sel)
      3'd2:    return (bus.id_pc & 32'hF000_0000) | (32'(bus.imm) << 2);
      3'd3:    return bus.rs_val;
      default: return bus.id_pc + 32'd4 + 32'(off);
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic step(input string tag);
    logic        tk;
    logic [31:0] tg;
    #1;
    tk = model_taken();
    tg = model_target();
    check({tag, "/boj"}, 32'(bus.boj), 32'(tk));
    check({tag, "/link"}, bus.link, bus.id_pc + 32'd8);
    if (reset) begin
      m_pc = 32'h3000; m_epc = 32'h0; m_bd = 1'b0; m_mis = 1'b0;
    end else if (bus.exc_req) begin
      m_pc = 32'h4180; m_epc = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
      m_bd = 1'b0; m_mis = 1'b0;
    end else if (bus.eret) begin
      m_pc = m_epc; m_bd = 1'b0; m_mis = 1'b0;
    end else if (bus.stall) begin
      m_mis = 1'b0;
    end else begin
      m_pc  = tk ? tg : m_pc + 32'd4;
      m_bd  = (bus.npc_sel >= 3'd1 && bus.npc_sel <= 3'd3);
      m_mis = (bus.npc_sel == 3'd3) && (bus.rs_val[1:0] != 2'b00);
    end
    @(posedge clk);
    #1;
    check({tag, "/pc"}, bus.pc, m_pc);
    check({tag, "/epc"}, bus.epc, m_epc);
    check({tag, "/id_bd"}, 32'(bus.id_bd), 32'(m_bd));
    check({tag, "/jr_misalign"}, 32'(bus.jr_misalign), 32'(m_mis));
  endtask

  task automatic idle();
    bus.stall = 0; bus.npc_sel = 0; bus.br_cond = 0; bus.imm = '0;
    bus.rs_val = '0; bus.rt_val = '0; bus.exc_req = 0; bus.exc_pc = '0;
    bus.exc_bd = 0; bus.eret = 0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] hold_pc;
    idle();
    bus.id_pc = 32'h3000;
    reset = 1'b1;
    m_pc = 32'h3000; m_epc = '0; m_bd = 1'b0; m_mis = 1'b0;
    step("rst0");
    step("rst1");
    check("rst_pc", bus.pc, 32'h3000);
    reset = 1'b0;
    step("seq0");
    check("seq0_pc", bus.pc, 32'h3004);
    step("seq1");
    check("seq1_pc", bus.pc, 32'h3008);

    // BEQ taken then not taken
    bus.npc_sel = 3'd1; bus.br_cond = 3'd0; bus.id_pc = 32'h3004;
    bus.rs_val = 32'd5; bus.rt_val = 32'd5; bus.imm = 26'h0003;
    step("beq_t");
    check("beq_t_pc", bus.pc, 32'h3014);
    check("beq_t_bd", 32'(bus.id_bd), 32'd1);
    bus.rt_val = 32'd6;
    step("beq_nt");
    check("beq_nt_pc", bus.pc, 32'h3018);
    check("beq_nt_bd", 32'(bus.id_bd), 32'd1);

    // Signed conditions
    bus.rs_val = 32'hFFFF_FFFF; bus.br_cond = 3'd4;
    #1 check("ltz_boj", 32'(bus.boj), 32'd1);
    step("ltz");
    bus.br_cond = 3'd5;
    #1 check("gez_boj", 32'(bus.boj), 32'd0);
    step("gez");
    bus.rs_val = 32'd0; bus.br_cond = 3'd2;
    #1 check("lez_boj", 32'(bus.boj), 32'd1);
    step("lez");
    bus.br_cond = 3'd3;
    #1 check("gtz_boj", 32'(bus.boj), 32'd0);
    step("gtz");

    // J and JR
    idle(); bus.npc_sel = 3'd2; bus.id_pc = 32'h3008; bus.imm = 26'h0000C40;
    #1 check("j_link", bus.link, 32'h3010);
    step("j");
    check("j_pc", bus.pc, 32'h3100);
    bus.npc_sel = 3'd3; bus.rs_val = 32'h3202;
    step("jr");
    check("jr_pc", bus.pc, 32'h3202);
    check("jr_mis", 32'(bus.jr_misalign), 32'd1);
    idle();
    step("jr_after");
    check("jr_mis_clr", 32'(bus.jr_misalign), 32'd0);

    // Stalled taken branch
    bus.npc_sel = 3'd1; bus.br_cond = 3'd0; bus.id_pc = 32'h3100;
    bus.imm = 26'h0010; bus.stall = 1'b1;
    hold_pc = bus.pc;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall_hold", bus.pc, hold_pc);
    bus.stall = 1'b0;
    step("stall_rel");
    check("stall_rel_pc", bus.pc, 32'h3144);

    // Exception, ERET, and both together
    idle(); bus.exc_req = 1'b1; bus.exc_pc = 32'h3010; bus.exc_bd = 1'b1; bus.stall = 1'b1;
    step("exc");
    check("exc_pc", bus.pc, 32'h4180);
    check("exc_epc", bus.epc, 32'h300C);
    idle();
    step("exc_seq");
    bus.eret = 1'b1;
    step("eret");
    check("eret_pc", bus.pc, 32'h300C);
    bus.exc_req = 1'b1; bus.exc_bd = 1'b0; bus.exc_pc = 32'h3020;
    step("exc_eret");
    check("exc_eret_pc", bus.pc, 32'h4180);
    check("exc_eret_epc", bus.epc, 32'h3020);

    // PC wraps modulo 2^32
    idle(); bus.npc_sel = 3'd3; bus.rs_val = 32'hFFFF_FFFC;
    step("wrap_jr");
    idle();
    step("wrap");
    check("wrap_pc", bus.pc, 32'h0);

    // Reset mid-operation discards a pending redirect
    bus.npc_sel = 3'd2; bus.imm = 26'h1234; reset = 1'b1;
    step("rst_mid");
    check("rst_mid_pc", bus.pc, 32'h3000);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      bus.stall   = ($urandom_range(0, 3) == 0);
      bus.exc_req = ($urandom_range(0, 15) == 0);
      bus.eret    = ($urandom_range(0, 15) == 0);
      bus.exc_bd  = 1'($urandom);
      bus.exc_pc  = $urandom & 32'hFFFF_FFFC;
      bus.npc_sel = 3'($urandom);
      bus.br_cond = 3'($urandom);
      bus.imm     = 26'($urandom);
      bus.id_pc   = $urandom & 32'hFFFF_FFFC;
      bus.rt_val  = $urandom;
      r = $urandom;
      case ($urandom_range(0, 4))
        0:       bus.rs_val = 32'h0;
        1:       bus.rs_val = 32'h1;
        2:       bus.rs_val = 32'hFFFF_FFFF;
        3:       bus.rs_val = bus.rt_val;
        default: bus.rs_val = r;
      endcase
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Next-generation fetch-PC block for the pipelined MIPS core: owns the PC register and computes the next fetch address.
- Covers sequential fetch, conditional branches (six condition modes), J/JAL, JR/JALR, exception entry and ERET return.
- Adds stall hold, branch-delay-slot tracking, an EPC register and JR misalignment detection.
- Sits between IF and ID: PC drives instruction memory; redirect inputs come from the ID stage.

Parameters:
- AW, 32: PC/address width; all address arithmetic is modulo 2^AW.
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_PC, 32'h0000_4180: exception entry vector.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and delay-slot state this cycle.
- npc_sel  in  3  ID instruction type: 000 seq, 001 branch, 010 J/JAL, 011 JR/JALR, others treated as seq.
- br_cond  in  3  branch mode: 000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ, others never taken.
- imm  in  26  ID instr_index; [15:0] is the branch offset.
- id_pc  in  AW  PC of the instruction in ID.
- rs_val  in  AW  forwarded rs value.
- rt_val  in  AW  forwarded rt value.
- exc_req  in  1  exception commit request.
- exc_pc  in  AW  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a delay slot.
- eret  in  1  ERET commit.
- pc  out  AW  current fetch PC (registered).
- boj  out  1  combinational: redirect taken this cycle.
- link  out  AW  id_pc+8 (JAL/JALR return address).
- epc  out  AW  registered exception PC.
- id_bd  out  1  registered: instruction now in ID is a delay slot.
- jr_misalign  out  1  registered one-cycle pulse: JR taken to a non-word-aligned target.

Behaviour:
- Reset values: pc=RESET_PC, epc=0, id_bd=0, jr_misalign=0. Reset overrides every other input.
- Branch offset: sign-extend imm[15:0], shift left 2, add to id_pc+4.
- J target: {id_pc[AW-1:28], imm, 2'b00}.
- JR target: rs_val unchanged, including low bits.
- Branch conditions, signed compares on AW bits:
  - EQ: rs==rt
  - NE: rs!=rt
  - LEZ: rs<=0
  - GTZ: rs>0
  - LTZ: rs<0
  - GEZ: rs>=0
- taken = (npc_sel==001 && cond) || npc_sel==010 || npc_sel==011; boj = taken.
- Next-PC priority, highest first:
  1. reset
  2. exc_req: pc<=EXC_PC
  3. eret: pc<=epc
  4. stall: pc holds
  5. taken: pc<=target
  6. otherwise: pc<=pc+4
- Delayed branching: the delay-slot instruction is already fetched at pc, so the redirect applies to the following fetch. Branch latency is one cycle, with no penalty beyond the delay slot.
- epc:
  - On exc_req: epc<=exc_bd ? exc_pc-4 : exc_pc. No other event writes epc.
  - exc_req and eret in the same cycle: exc_req wins, and epc still loads.
- id_bd:
  - On a non-stalled cycle, id_bd<=taken || npc_sel in {001,010,011}. A not-taken branch still marks its delay slot.
  - On stall: hold.
  - On exc_req or eret: clear to 0.
- jr_misalign: set for one cycle when npc_sel==011, not stalled, no exc/eret, and rs_val[1:0]!=0. The redirect still occurs; the exception unit consumes the flag.
- stall with exc_req: the exception wins and the PC moves.
- pc+4 wraps modulo 2^AW; there is no overflow flag.
- Reset mid-operation discards any pending redirect; the next cycle fetches RESET_PC.

Test Plan:
- Reset: hold reset 2 cycles, then release with npc_sel=000 -> pc 0x3000, then 0x3004, then 0x3008; epc=0, id_bd=0.
- BEQ forward: id_pc=0x3004, rs=rt=5, imm=0x0003 -> boj=1; next pc=0x3014; id_bd=1 the following cycle. With rt=6 instead -> boj=0, pc=pc+4, id_bd=1.
- Signed conditions: rs=0xFFFF_FFFF with LTZ -> taken; GEZ -> not taken; LEZ with rs=0 -> taken; GTZ with rs=0 -> not taken.
- J and JR: id_pc=0x3008, imm=0x0000C40 -> pc=0x0000_3100, link=0x3010. JR with rs=0x3202 -> pc=0x3202 and jr_misalign pulses 1 for one cycle.
- Stall: taken branch asserted with stall=1 for 3 cycles -> pc constant; redirect occurs on the first cycle with stall=0.
- Exception/ERET: exc_req with exc_pc=0x3010, exc_bd=1 -> pc=0x4180, epc=0x300C, id_bd=0. Later eret -> pc=0x300C. exc_req and eret together -> pc=0x4180.
